// File: rtl/multi_counter_pkg.sv
// Shared types and helpers for the multi-lane event counter.
package multi_counter_pkg;

   typedef enum {MODE_WRAP, MODE_SAT} cnt_mode_e;

   typedef enum logic {SNAP_IDLE, SNAP_DRAIN} snap_state_e;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_counter_counter_lane.sv
// One counter lane: load > (inc xor dec) > hold, with wrap or saturate at
// the 0 / MAX_COUNT bounds and a registered terminal-count pulse.
module counter_lane
   import multi_counter_pkg::*;
#(
   parameter int        WIDTH     = 16,
   parameter int        MAX_COUNT = 2**WIDTH - 1,
   parameter cnt_mode_e MODE      = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_in,
   input  logic             dec_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] load_val_in,
   output logic [WIDTH-1:0] count_out,
   output logic             tc_out
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load_in) begin
         count_d = (load_val_in > MAX_C) ? MAX_C : load_val_in;
      end else if (inc_in && !dec_in) begin
         if (count_q >= MAX_C) begin
            tc_d    = 1'b1;
            count_d = (MODE == MODE_SAT) ? MAX_C : '0;
         end else begin
            count_d = count_q + ONE;
         end
      end else if (dec_in && !inc_in) begin
         if (count_q == '0) begin
            tc_d    = 1'b1;
            count_d = (MODE == MODE_SAT) ? '0 : MAX_C;
         end else begin
            count_d = count_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count_out = count_q;
   assign tc_out    = tc_q;

endmodule

// File: rtl/multi_counter.sv
// NUM_CH independent counter lanes plus a snapshot engine that freezes all
// lanes at once and streams them out one word per valid/ready handshake.
//
//  state      | meaning
//  SNAP_IDLE  | waiting for snap_req_in; readout idle
//  SNAP_DRAIN | presenting shadow[idx] until the last lane is accepted
module multi_counter
   import multi_counter_pkg::*;
#(
   parameter int        WIDTH     = 16,
   parameter int        NUM_CH    = 4,
   parameter int        MAX_COUNT = 2**WIDTH - 1,
   parameter cnt_mode_e MODE      = MODE_WRAP,
   localparam int       CH_W      = ch_width(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       inc_in,
   input  logic [NUM_CH-1:0]       dec_in,
   input  logic [NUM_CH-1:0]       load_in,
   input  logic [WIDTH-1:0]        load_val_in,
   output logic [NUM_CH*WIDTH-1:0] count_out,
   output logic [NUM_CH-1:0]       tc_out,
   input  logic                    snap_req_in,
   output logic                    snap_busy_out,
   output logic                    rd_valid_out,
   input  logic                    rd_ready_in,
   output logic [CH_W-1:0]         rd_chan_out,
   output logic [WIDTH-1:0]        rd_data_out
);

   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
   localparam logic [CH_W-1:0] ONE_IDX  = CH_W'(1);

   logic [WIDTH-1:0] lane_cnt [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      counter_lane #(
         .WIDTH     (WIDTH),
         .MAX_COUNT (MAX_COUNT),
         .MODE      (MODE)
      ) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .inc_in      (inc_in[i]),
         .dec_in      (dec_in[i]),
         .load_in     (load_in[i]),
         .load_val_in (load_val_in),
         .count_out   (lane_cnt[i]),
         .tc_out      (tc_out[i])
      );
      assign count_out[i*WIDTH +: WIDTH] = lane_cnt[i];
   end

   snap_state_e      state_q, state_d;
   logic [CH_W-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] shadow_q [NUM_CH];
   logic [WIDTH-1:0] shadow_d [NUM_CH];
   logic             valid_q, valid_d;
   logic [CH_W-1:0]  chan_q, chan_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      case (state_q)
         SNAP_IDLE: begin
            if (snap_req_in) begin
               shadow_d = lane_cnt;
               idx_d    = '0;
               state_d  = SNAP_DRAIN;
            end
         end
         SNAP_DRAIN: begin
            // Requests here are dropped, including one coinciding with the last handshake.
            if (rd_ready_in) begin
               if (idx_q == LAST_IDX) begin
                  state_d = SNAP_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + ONE_IDX;
               end
            end
         end
      endcase
      // Readout outputs are registered from the next state so they line up with it.
      valid_d = (state_d == SNAP_DRAIN);
      chan_d  = valid_d ? idx_d : '0;
      data_d  = valid_d ? shadow_d[idx_d] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= SNAP_IDLE;
         idx_q    <= '0;
         shadow_q <= '{default: '0};
         valid_q  <= 1'b0;
         chan_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         valid_q  <= valid_d;
         chan_q   <= chan_d;
         data_q   <= data_d;
      end
   end

   assign snap_busy_out = valid_q;
   assign rd_valid_out  = valid_q;
   assign rd_chan_out   = chan_q;
   assign rd_data_out   = data_q;

endmodule

// File: tb/tb_multi_counter.sv
// Bench for multi_counter: wrap, saturate and single-lane builds driven in
// parallel, checked every cycle against an arithmetic/queue model.
module tb_multi_counter;
   import multi_counter_pkg::*;

   localparam int MAXC = 9;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] inc, dec, load;
   logic [7:0] lv;
   logic       req, rdy;

   logic [31:0] cnt_w, cnt_s;
   logic [7:0]  cnt_1;
   logic [3:0]  tc_w, tc_s;
   logic        tc_1;
   logic        busy_w, busy_s, busy_1, val_w, val_s, val_1;
   logic [1:0]  chan_w, chan_s;
   logic        chan_1;
   logic [7:0]  data_w, data_s, data_1;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   multi_counter #(.WIDTH(8), .NUM_CH(4), .MAX_COUNT(MAXC), .MODE(MODE_WRAP)) u_w (
      .clk(clk), .rst_n(rst_n), .inc_in(inc), .dec_in(dec), .load_in(load), .load_val_in(lv),
      .count_out(cnt_w), .tc_out(tc_w), .snap_req_in(req), .snap_busy_out(busy_w),
      .rd_valid_out(val_w), .rd_ready_in(rdy), .rd_chan_out(chan_w), .rd_data_out(data_w));

   multi_counter #(.WIDTH(8), .NUM_CH(4), .MAX_COUNT(MAXC), .MODE(MODE_SAT)) u_s (
      .clk(clk), .rst_n(rst_n), .inc_in(inc), .dec_in(dec), .load_in(load), .load_val_in(lv),
      .count_out(cnt_s), .tc_out(tc_s), .snap_req_in(req), .snap_busy_out(busy_s),
      .rd_valid_out(val_s), .rd_ready_in(rdy), .rd_chan_out(chan_s), .rd_data_out(data_s));

   multi_counter #(.WIDTH(8), .NUM_CH(1), .MAX_COUNT(MAXC), .MODE(MODE_WRAP)) u_1 (
      .clk(clk), .rst_n(rst_n), .inc_in(inc[0]), .dec_in(dec[0]), .load_in(load[0]),
      .load_val_in(lv), .count_out(cnt_1), .tc_out(tc_1), .snap_req_in(req),
      .snap_busy_out(busy_1), .rd_valid_out(val_1), .rd_ready_in(rdy), .rd_chan_out(chan_1),
      .rd_data_out(data_1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, want);
      end
   endtask

   // ---------------- model: instance 0 = wrap, 1 = sat, 2 = single lane
   int nch [3]    = '{4, 4, 1};
   bit is_sat [3] = '{1'b0, 1'b1, 1'b0};
   int m_cnt [3][4];
   bit m_tc [3][4];
   int wq [3][$];   // pending readout words, chan*256 + data
   bit mb;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            wq[k].delete();
         end else begin
            mb = (wq[k].size() > 0);
            if (mb && rdy) void'(wq[k].pop_front());
            if (!mb && req)
               for (int l = 0; l < nch[k]; l++) wq[k].push_back(l * 256 + m_cnt[k][l]);
         end
         for (int l = 0; l < nch[k]; l++) begin
            if (!rst_n) begin
               m_cnt[k][l] = 0;
               m_tc[k][l]  = 1'b0;
            end else if (load[l]) begin
               m_cnt[k][l] = (int'(lv) > MAXC) ? MAXC : int'(lv);
               m_tc[k][l]  = 1'b0;
            end else if (inc[l] && !dec[l]) begin
               m_tc[k][l]  = (m_cnt[k][l] == MAXC);
               m_cnt[k][l] = is_sat[k] ? ((m_cnt[k][l] + 1 > MAXC) ? MAXC : m_cnt[k][l] + 1)
                                       : (m_cnt[k][l] + 1) % (MAXC + 1);
            end else if (dec[l] && !inc[l]) begin
               m_tc[k][l]  = (m_cnt[k][l] == 0);
               m_cnt[k][l] = is_sat[k] ? ((m_cnt[k][l] - 1 < 0) ? 0 : m_cnt[k][l] - 1)
                                       : (m_cnt[k][l] + MAXC) % (MAXC + 1);
            end else begin
               m_tc[k][l] = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare
   logic [31:0] cc;
   logic [3:0]  tt;
   logic        vv, bb;
   logic [7:0]  ch, dt;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            case (k)
               0:       begin cc = cnt_w; tt = tc_w; vv = val_w; bb = busy_w; ch = {6'b0, chan_w}; dt = data_w; end
               1:       begin cc = cnt_s; tt = tc_s; vv = val_s; bb = busy_s; ch = {6'b0, chan_s}; dt = data_s; end
               default: begin cc = {24'b0, cnt_1}; tt = {3'b0, tc_1}; vv = val_1; bb = busy_1; ch = {7'b0, chan_1}; dt = data_1; end
            endcase
            for (int l = 0; l < nch[k]; l++) begin
               chk($sformatf("model_cnt i%0d l%0d", k, l), {24'b0, cc[l*8 +: 8]}, m_cnt[k][l]);
               chk($sformatf("model_tc i%0d l%0d", k, l), {31'b0, tt[l]}, {31'b0, m_tc[k][l]});
            end
            chk($sformatf("model_valid i%0d", k), {31'b0, vv}, (wq[k].size() > 0) ? 1 : 0);
            chk($sformatf("model_busy i%0d", k), {31'b0, bb}, (wq[k].size() > 0) ? 1 : 0);
            if (wq[k].size() > 0) begin
               chk($sformatf("model_chan i%0d", k), {24'b0, ch}, wq[k][0] / 256);
               chk($sformatf("model_data i%0d", k), {24'b0, dt}, wq[k][0] % 256);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   int got_ch [8];
   int got_dt [8];
   int words, n1, d1, vcnt;

   initial begin
      // 1. reset with strobes active
      rst_n = 1'b0; inc = 4'hF; dec = 4'h0; load = 4'hF; lv = 8'd3; req = 1'b1; rdy = 1'b1;
      step(); step();
      chk("rst_count", cnt_w, 0);
      chk("rst_tc", {28'b0, tc_w}, 0);
      chk("rst_valid", {31'b0, val_w}, 0);
      chk("rst_busy", {31'b0, busy_w}, 0);
      chk("rst_chan", {30'b0, chan_w}, 0);
      chk("rst_data", {24'b0, data_w}, 0);
      chk_en = 1'b1;
      rst_n = 1'b1; inc = 4'b0001; load = 4'h0; req = 1'b0; rdy = 1'b0;
      repeat (3) step();
      inc = 4'h0;
      chk("inc3_lane0", {24'b0, cnt_w[7:0]}, 3);
      chk("inc3_single", {24'b0, cnt_1}, 3);

      // 2. wrap on lane 1
      inc = 4'b0010;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 9) begin
            chk("wrap_at9", {24'b0, cnt_w[15:8]}, 9);
            chk("wrap_tc_at9", {31'b0, tc_w[1]}, 0);
         end
      end
      chk("wrap_to0", {24'b0, cnt_w[15:8]}, 0);
      chk("wrap_tc", {31'b0, tc_w[1]}, 1);
      chk("sat_hold9", {24'b0, cnt_s[15:8]}, 9);
      inc = 4'h0; dec = 4'b0010;
      step();
      chk("wrap_dec0", {24'b0, cnt_w[15:8]}, 9);
      chk("wrap_dec_tc", {31'b0, tc_w[1]}, 1);
      dec = 4'h0;
      step();
      chk("wrap_tc_drop", {31'b0, tc_w[1]}, 0);

      // 3. saturate on lane 2
      load = 4'b0100; lv = 8'd12;
      step();
      chk("sat_load12", {24'b0, cnt_s[23:16]}, 9);
      chk("sat_load_tc", {31'b0, tc_s[2]}, 0);
      load = 4'h0; inc = 4'b0100;
      step();
      chk("sat_inc1", {24'b0, cnt_s[23:16]}, 9);
      chk("sat_inc1_tc", {31'b0, tc_s[2]}, 1);
      step();
      chk("sat_inc2", {24'b0, cnt_s[23:16]}, 9);
      chk("sat_inc2_tc", {31'b0, tc_s[2]}, 1);
      inc = 4'h0; load = 4'b0100; lv = 8'd0;
      step();
      load = 4'h0; dec = 4'b0100;
      step();
      chk("sat_dec0", {24'b0, cnt_s[23:16]}, 0);
      chk("sat_dec0_tc", {31'b0, tc_s[2]}, 1);
      dec = 4'h0;

      // 4. priority on lane 3
      load = 4'b1000; lv = 8'd5; inc = 4'b1000; dec = 4'b1000;
      step();
      chk("prio_load", {24'b0, cnt_w[31:24]}, 5);
      load = 4'h0;
      step();
      chk("prio_hold", {24'b0, cnt_w[31:24]}, 5);
      chk("prio_hold_tc", {31'b0, tc_w[3]}, 0);
      inc = 4'h0; dec = 4'h0;

      // 5. snapshot of {1,2,3,4} with stalls and counting during drain
      for (int l = 0; l < 4; l++) begin
         load = 4'(1 << l); lv = 8'(l + 1);
         step();
      end
      load = 4'h0;
      req = 1'b1; rdy = 1'b0; inc = 4'hF;
      step();
      req = 1'b0; inc = 4'h0;
      chk("snap_first_valid", {31'b0, val_w}, 1);
      words = 0; n1 = 0; d1 = -1;
      for (int c = 0; c < 40 && (busy_w || busy_1); c++) begin
         rdy = (c % 2 == 1);
         inc = (c % 3 == 0) ? 4'hF : 4'h0;
         if (val_w && rdy && words < 8) begin
            got_ch[words] = int'(chan_w);
            got_dt[words] = int'(data_w);
            words++;
         end
         if (val_1 && rdy) begin
            n1++;
            d1 = int'(data_1);
         end
         step();
      end
      rdy = 1'b0; inc = 4'h0;
      chk("snap_words", words, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("snap_chan%0d", i), got_ch[i], i);
         chk($sformatf("snap_data%0d", i), got_dt[i], i + 1);
      end
      chk("single_words", n1, 1);
      chk("single_data", d1, 1);

      // 6. reset aborts a drain after two handshakes
      req = 1'b1; rdy = 1'b1;
      step();
      req = 1'b0;
      step(); step();
      rst_n = 1'b0;
      step();
      chk("abort_valid", {31'b0, val_w}, 0);
      chk("abort_busy", {31'b0, busy_w}, 0);
      rst_n = 1'b1;
      vcnt = 0;
      repeat (4) begin
         step();
         if (val_w) vcnt++;
      end
      chk("abort_no_words", vcnt, 0);

      // requests held through the whole drain, including the last handshake edge
      req = 1'b1; rdy = 1'b0;
      step(); step(); step();
      rdy = 1'b1;
      words = 0;
      for (int c = 0; c < 20 && words < 4; c++) begin
         if (val_w && rdy) words++;
         step();
      end
      req = 1'b0;
      vcnt = 0;
      repeat (3) begin
         step();
         if (val_w) vcnt++;
      end
      chk("ignore_words", words, 4);
      chk("ignore_no_second", vcnt, 0);
      rdy = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
